serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
//   Downstream consumer of the 4-stage serial shift chain output (op).
//   Frames the serial bit stream: detects start bit, shifts in DATA_W bits
//   LSB-first, checks optional parity and stop bit.
//   Presents the word on a one-entry valid/ready output buffer.
//   Reports parity, framing and overrun errors.
// PARAMETERS
//   DATA_W     8  data bits per frame (1..16)
//   PARITY_EN  1  1 = parity bit follows data; 0 = no parity bit
//   PARITY_ODD 0  0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
// PORTS
//   clk         in   1       single clock; all state updates on rising edge
//   reset       in   1       synchronous, active-low reset
//   sin         in   1       serial data in; idle-high line
//   bit_en      in   1       bit-rate strobe; sin sampled only when bit_en=1
//   dout        out  DATA_W  received word (buffer contents)
//   dout_valid  out  1       buffer holds an unconsumed word
//   dout_ready  in   1       consumer accepts word when dout_valid & dout_ready
//   parity_err  out  1       parity status of the word in the buffer; changes with dout
//   frame_err   out  1       1-cycle pulse: stop bit sampled 0
//   overrun     out  1       1-cycle pulse: completed word dropped, buffer full
//   busy        out  1       FSM not in IDLE
// BEHAVIOUR
//   Reset (reset=0 at a clk edge): FSM->IDLE, bit count=0, shift reg=0, dout=0,
//     dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
//     Applies mid-frame: the partial frame is discarded, including any buffered word.
//   Cycles with bit_en=0: FSM, counter and shifter hold; the buffer handshake still operates.
//   FSM (transitions only on bit_en=1 cycles):
//     IDLE   : sin=0 -> DATA, cnt=0; sin=1 -> stay.
//     DATA   : shift sin into MSB, shift right (LSB-first); cnt++.
//              When cnt==DATA_W-1: -> PARITY if PARITY_EN, else -> STOP.
//     PARITY : capture sin as rx parity -> STOP.
//     STOP   : sin=1 -> frame complete (commit); sin=0 -> frame_err pulse,
//              word discarded, no commit. Both cases -> IDLE.
//   A new start bit is honoured on the first bit_en after STOP. No idle gap is required.
//   Parity: err = (^data ^ rxpar) != PARITY_ODD. parity_err=0 when PARITY_EN=0.
//   Commit (the cycle after the stop-bit sample edge):
//     Buffer empty, or dout_valid & dout_ready in the commit cycle:
//       load dout/parity_err; dout_valid=1.
//     Buffer full and dout_ready=0: old word kept; overrun pulses 1 cycle.
//   Latency: dout_valid rises 1 clk after the rising edge that samples the stop bit.
//   Handshake: dout and parity_err stable while dout_valid & !dout_ready.
//     dout_valid falls the cycle after the accept, unless a commit reloads the buffer.
//   frame_err and overrun never assert in the same cycle as reset.
// STRUCTURE
//   Shared package serial_pkg:
//     FSM state encodings ST_IDLE/ST_DATA/ST_PARITY/ST_STOP (2-bit)
//     START_BIT=0, STOP_BIT=1 constants
//   Sub-module serial_shift_in:
//     DATA_W-bit right shift register with shift enable and sync clear
//     Instantiated once for the data path
//   Top holds the FSM, bit counter, parity check, output buffer and flags.
// TESTING (DATA_W=8, PARITY_EN=1, PARITY_ODD=0; bit_en every 4th clk)
//   0xA5 framed 0,1,0,1,0,0,1,0,1,par=0,stop=1, dout_ready=1
//     -> dout=0xA5, parity_err=0, dout_valid high 1 cycle.
//   0x3C sent with par=1 -> dout=0x3C, parity_err=1, frame_err=0.
//   0x55 sent with stop=0 -> frame_err 1-cycle pulse; dout_valid stays 0;
//     next frame 0x0F is received correctly.
//   dout_ready=0; send 0x11 then 0x22
//     -> dout=0x11 held, overrun pulses at 0x22 commit.
//     Raise ready -> 0x11 accepted, then dout_valid=0.
//   Ready held 0 until the commit cycle of 2nd frame 0x22, then ready=1
//     -> 0x11 accepted, 0x22 loaded same edge, no overrun.
//   reset=0 for 1 clk mid-DATA of 0xFF -> busy=0, no output.
//     Subsequent 0x81 received intact.
//   PARITY_EN=0 build: 0xC3 with no parity bit -> dout=0xC3, parity_err=0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver: FSM encodings, line levels
// and the parity-check helper.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Wide enough to count up to 16 data bits
  localparam int CNT_W = 5;

  function automatic logic parity_bad(input logic data_xor, input logic rx_par, input logic odd);
    return ((data_xor ^ rx_par) != odd);
  endfunction

endpackage

// File: rtl/serial_shift_in.sv
// Right shift register fed at the MSB, so an LSB-first stream lands in order.
module serial_shift_in #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] shifted;

  generate
    if (W == 1) begin : g_one
      assign shifted = din;
    end else begin : g_many
      assign shifted = {din, q[W-1:1]};
    end
  endgenerate

  // Clear has priority over shifting
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (shift_en) begin
      q <= shifted;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Frames an idle-high serial stream into words with parity/stop checks and
// presents them through a one-entry valid/ready buffer.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sin,
  input  logic              bit_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam logic HAS_PAR = (PARITY_EN != 0);
  localparam logic ODD     = (PARITY_ODD != 0);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              rxpar;
  logic              commit_pend;
  logic              last_bit;
  logic              shift_en;
  logic              cnt_clr;
  logic              par_cap;
  logic              stop_ok;
  logic              stop_bad;
  logic              par_now;

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));
  assign par_now  = HAS_PAR ? parity_bad(^shreg, rxpar, ODD) : 1'b0;

  serial_shift_in #(.W(DATA_W)) u_shift (
    .clk      (clk),
    .clear    (!reset || cnt_clr),
    .shift_en (shift_en),
    .din      (sin),
    .q        (shreg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bit_en) begin
      case (state)
        ST_IDLE:   state_nx = (sin == START_BIT) ? ST_DATA : ST_IDLE;
        ST_DATA:   state_nx = last_bit ? (HAS_PAR ? ST_PARITY : ST_STOP) : ST_DATA;
        ST_PARITY: state_nx = ST_STOP;
        ST_STOP:   state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end else begin
      state_nx = state;
    end
  end

  always_comb begin
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    par_cap  = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    busy     = (state != ST_IDLE);
    if (bit_en) begin
      case (state)
        ST_IDLE:   cnt_clr  = (sin == START_BIT);
        ST_DATA:   shift_en = 1'b1;
        ST_PARITY: par_cap  = 1'b1;
        ST_STOP: begin
          stop_ok  = (sin == STOP_BIT);
          stop_bad = (sin != STOP_BIT);
        end
        default:   cnt_clr  = 1'b0;
      endcase
    end else begin
      shift_en = 1'b0;
    end
  end

  // Bit counter, received parity bit and the one-cycle commit/frame-error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      rxpar       <= 1'b0;
      commit_pend <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      commit_pend <= stop_ok;
      frame_err   <= stop_bad;
      rxpar       <= par_cap ? sin : rxpar;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= cnt;
      end
    end
  end

  // Output buffer: a commit may refill it on the same edge the consumer drains it
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit_pend) begin
      if (!dout_valid || dout_ready) begin
        dout       <= shreg;
        parity_err <= par_now;
        dout_valid <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun    <= 1'b1;
      end
    end else begin
      overrun <= 1'b0;
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end else begin
        dout_valid <= dout_valid;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: a parity build and a no-parity build,
// bit_en strobed every 4th clock.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sin = 1'b1;
  logic       sin2 = 1'b1;
  logic       bit_en = 1'b0;
  logic       dout_ready = 1'b1;
  logic       dout_ready2 = 1'b1;
  logic [7:0] dout, dout2;
  logic       dout_valid, parity_err, frame_err, overrun, busy;
  logic       dout_valid2, parity_err2, frame_err2, overrun2, busy2;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cyc = 0;
  int fe_cyc = 0;
  int ov_cyc = 0;
  bit chan = 1'b0;
  logic [8:0] acc_q[$];
  logic [8:0] acc2_q[$];

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .sin(sin), .bit_en(bit_en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
    .clk(clk), .reset(reset), .sin(sin2), .bit_en(bit_en),
    .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready2),
    .parity_err(parity_err2), .frame_err(frame_err2), .overrun(overrun2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // Observe handshakes and pulse flags half a cycle away from the active edge
  always @(negedge clk) begin
    if (dout_valid && dout_ready) acc_q.push_back({parity_err, dout});
    if (dout_valid2 && dout_ready2) acc2_q.push_back({parity_err2, dout2});
    if (dout_valid) valid_cyc++;
    if (frame_err) fe_cyc++;
    if (overrun) ov_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [8:0] exp, input bit np);
    logic [8:0] w;
    int sz;
    sz = np ? acc2_q.size() : acc_q.size();
    check({tag, "_cnt"}, 32'(sz), 32'd1);
    if (sz > 0) begin
      w = np ? acc2_q.pop_front() : acc_q.pop_front();
      check(tag, {23'd0, w}, {23'd0, exp});
    end
  endtask

  task automatic send_bit(input logic b);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bit_en = 1'b0;
      if (chan) sin2 = b; else sin = b;
    end
    @(posedge clk); #1;
    bit_en = 1'b1;
  endtask

  // Returns just after the edge that samples the stop bit
  task automatic send_frame(input logic [7:0] data, input bit with_par, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (with_par) send_bit(par);
    send_bit(stop);
    @(posedge clk); #1;
    bit_en = 1'b0;
    if (chan) sin2 = 1'b1; else sin = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  int v0, f0, o0;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_dout", {24'd0, dout}, 32'h0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);

    // 0xA5 with latency and single-cycle valid
    v0 = valid_cyc;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("a5_lat_pre", {31'd0, dout_valid}, 32'd0);
    @(negedge clk);
    check("a5_lat_rise", {31'd0, dout_valid}, 32'd1);
    idle_bits(2);
    check("a5_valid_cyc", 32'(valid_cyc - v0), 32'd1);
    expect_word("a5_word", {1'b0, 8'hA5}, 1'b0);

    // 0x3C with wrong parity bit
    f0 = fe_cyc;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle_bits(2);
    expect_word("3c_word", {1'b1, 8'h3C}, 1'b0);
    check("3c_no_fe", 32'(fe_cyc - f0), 32'd0);

    // 0x55 with bad stop bit, then 0x0F back-to-back-ish
    f0 = fe_cyc; v0 = valid_cyc;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    idle_bits(2);
    check("55_fe_pulse", 32'(fe_cyc - f0), 32'd1);
    check("55_no_valid", 32'(valid_cyc - v0), 32'd0);
    check("55_no_word", 32'(acc_q.size()), 32'd0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
    idle_bits(2);
    expect_word("0f_word", {1'b0, 8'h0F}, 1'b0);

    // Overrun: ready low across two frames
    dout_ready = 1'b0;
    o0 = ov_cyc;
    send_frame(8'h11, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    @(negedge clk);
    check("ovr_pulse", 32'(ov_cyc - o0), 32'd1);
    check("ovr_hold_dout", {24'd0, dout}, 32'h11);
    check("ovr_hold_valid", {31'd0, dout_valid}, 32'd1);
    @(posedge clk); #1 dout_ready = 1'b1;
    idle_bits(1);
    expect_word("ovr_accept", {1'b0, 8'h11}, 1'b0);
    check("ovr_drained", {31'd0, dout_valid}, 32'd0);

    // Accept and reload on the same edge
    dout_ready = 1'b0;
    o0 = ov_cyc;
    send_frame(8'h11, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    dout_ready = 1'b1;
    @(negedge clk);
    check("swap_old", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h11});
    @(negedge clk);
    check("swap_new", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h22});
    idle_bits(1);
    check("swap_no_ovr", 32'(ov_cyc - o0), 32'd0);
    check("swap_cnt", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      check("swap_first", {23'd0, acc_q.pop_front()}, {23'd0, 1'b0, 8'h11});
      check("swap_second", {23'd0, acc_q.pop_front()}, {23'd0, 1'b0, 8'h22});
    end
    check("swap_drained", {31'd0, dout_valid}, 32'd0);

    // Reset mid-DATA of 0xFF
    f0 = fe_cyc;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    @(posedge clk); #1 bit_en = 1'b0;
    @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_valid", {31'd0, dout_valid}, 32'd0);
    idle_bits(3);
    check("rst_mid_noword", 32'(acc_q.size()), 32'd0);
    check("rst_mid_nofe", 32'(fe_cyc - f0), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    idle_bits(2);
    expect_word("81_word", {1'b0, 8'h81}, 1'b0);

    // No-parity build
    chan = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    idle_bits(2);
    chan = 1'b0;
    expect_word("np_c3_word", {1'b0, 8'hC3}, 1'b1);
    check("np_main_quiet", 32'(acc_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
